// File: rtl/picture_fetch_server.sv
// picture_fetch_server: round-robin read arbiter in front of one single-port
// picture SRAM. Requests for the same address in the same cycle share one
// SRAM access, and the grant mask follows the read through a delay line so
// that the returning data is flagged to every unit that was served.
module picture_fetch_server #(
    parameter int N_UNITS  = 16,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_UNITS-1:0]          req_valid,
    input  logic [N_UNITS*ADDR_W-1:0]   req_addr,
    output logic [N_UNITS-1:0]          req_ready,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [N_UNITS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [31:0]                 access_cnt,
    output logic [31:0]                 coalesce_cnt
);

    localparam int PTR_W = $clog2(N_UNITS);
    localparam int POP_W = $clog2(N_UNITS + 1);

    logic [PTR_W-1:0]   r_ptr;
    logic               r_mem_en;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [N_UNITS-1:0] r_mask_pipe [READ_LAT+1];
    logic [31:0]        r_access_cnt;
    logic [31:0]        r_coalesce_cnt;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [N_UNITS-1:0] w_grant;
    logic [POP_W-1:0]   w_pop;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [32:0]        w_coal_sum;

    // Cyclic scan from the priority pointer: first valid request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % N_UNITS]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'((int'(r_ptr) + k) % N_UNITS);
            end
        end
    end

    assign w_win_addr = req_addr[int'(w_winner)*ADDR_W +: ADDR_W];

    // Grant the winner plus every valid unit asking for the identical address.
    always_comb begin
        w_grant = '0;
        for (int j = 0; j < N_UNITS; j++) begin
            if (w_found && req_valid[j] && (req_addr[j*ADDR_W +: ADDR_W] == w_win_addr)) begin
                w_grant[j] = 1'b1;
            end
        end
    end

    assign w_pop      = POP_W'($countones(w_grant));
    assign w_ptr_next = (w_winner == PTR_W'(N_UNITS - 1)) ? '0 : w_winner + 1'b1;
    // Only consumed on grant cycles, where w_pop is at least 1.
    assign w_coal_sum = {1'b0, r_coalesce_cnt} + 33'(w_pop) - 33'd1;

    // Pointer advances past the winner only; coalesced units leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

    // SRAM command register; the address holds across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_en <= w_found;
            if (w_found) begin
                r_mem_addr <= w_win_addr;
            end
        end
    end

    // Grant mask delay line, aligned with read data returning READ_LAT later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= READ_LAT; s++) begin
                r_mask_pipe[s] <= '0;
            end
        end else begin
            r_mask_pipe[0] <= w_grant;
            for (int s = 1; s <= READ_LAT; s++) begin
                r_mask_pipe[s] <= r_mask_pipe[s-1];
            end
        end
    end

    // Saturating statistics: accesses issued and extra grants sharing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_access_cnt   <= '0;
            r_coalesce_cnt <= '0;
        end else if (w_found) begin
            if (r_access_cnt != '1) begin
                r_access_cnt <= r_access_cnt + 32'd1;
            end
            r_coalesce_cnt <= w_coal_sum[32] ? '1 : w_coal_sum[31:0];
        end
    end

    assign req_ready    = w_grant;
    assign mem_en       = r_mem_en;
    assign mem_addr     = r_mem_addr;
    assign rsp_valid    = r_mask_pipe[READ_LAT];
    assign rsp_data     = mem_rdata;
    assign access_cnt   = r_access_cnt;
    assign coalesce_cnt = r_coalesce_cnt;

endmodule

// File: tb/tb_picture_fetch_server.sv
// Bench for picture_fetch_server: two instances (READ_LAT 1 and 3) share one
// request stream; a time-scheduled model predicts every output each cycle,
// and directed literal checks pin the model to hand-computed values.
module tb_picture_fetch_server;

    localparam int NU = 16;
    localparam int AW = 17;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NU-1:0]        req_valid = '0;
    logic [NU*AW-1:0]     req_addr;
    logic [AW-1:0]        ua [NU];

    logic [NU-1:0]        ready1, ready3, rsp_valid1, rsp_valid3;
    logic                 mem_en1, mem_en3;
    logic [AW-1:0]        mem_addr1, mem_addr3;
    logic [DW-1:0]        mem_rdata1, mem_rdata3, rsp_data1, rsp_data3;
    logic [31:0]          acc1, acc3, coal1, coal3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        for (int j = 0; j < NU; j++) req_addr[j*AW +: AW] = ua[j];
    end

    picture_fetch_server #(.N_UNITS(NU), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .access_cnt(acc1), .coalesce_cnt(coal1));

    picture_fetch_server #(.N_UNITS(NU), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready3),
        .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .access_cnt(acc3), .coalesce_cnt(coal3));

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 17'h00100) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h3C;
    endfunction

    // SRAM models: latency 1 and latency 3.
    logic [DW-1:0] s1_q;
    logic [DW-1:0] s3_q [3];
    always @(posedge clk) begin
        if (mem_en1) s1_q <= mem_fn(mem_addr1);
        if (mem_en3) s3_q[0] <= mem_fn(mem_addr3);
        s3_q[1] <= s3_q[0];
        s3_q[2] <= s3_q[1];
    end
    assign mem_rdata1 = s1_q;
    assign mem_rdata3 = s3_q[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: responses are scheduled into future-cycle slots.
    int            cyc = 0;
    int            m_ptr = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            m_acc = 0;
    int            m_coal = 0;
    logic [NU-1:0] sl1_mask [8];
    logic [DW-1:0] sl1_data [8];
    logic [NU-1:0] sl3_mask [8];
    logic [DW-1:0] sl3_data [8];
    int            winners [$];
    int            win;
    logic [NU-1:0] m_mask;

    initial begin
        for (int s = 0; s < 8; s++) begin
            sl1_mask[s] = '0; sl3_mask[s] = '0; sl1_data[s] = '0; sl3_data[s] = '0;
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            m_ptr = 0; m_en = 1'b0; m_addr = '0; m_acc = 0; m_coal = 0;
            for (int s = 0; s < 8; s++) begin sl1_mask[s] = '0; sl3_mask[s] = '0; end
            winners.delete();
        end
        win = -1;
        for (int k = 0; k < NU; k++) begin
            if (win < 0 && req_valid[(m_ptr + k) % NU]) win = (m_ptr + k) % NU;
        end
        m_mask = '0;
        if (win >= 0)
            for (int j = 0; j < NU; j++)
                if (req_valid[j] && ua[j] == ua[win]) m_mask[j] = 1'b1;

        chk("ready_l1", 32'(ready1), 32'(m_mask));
        chk("ready_l3", 32'(ready3), 32'(m_mask));
        chk("mem_en_l1", 32'(mem_en1), 32'(m_en));
        chk("mem_en_l3", 32'(mem_en3), 32'(m_en));
        chk("mem_addr_l1", 32'(mem_addr1), 32'(m_addr));
        chk("mem_addr_l3", 32'(mem_addr3), 32'(m_addr));
        chk("rsp_valid_l1", 32'(rsp_valid1), 32'(sl1_mask[cyc % 8]));
        chk("rsp_valid_l3", 32'(rsp_valid3), 32'(sl3_mask[cyc % 8]));
        if (sl1_mask[cyc % 8] != '0) chk("rsp_data_l1", 32'(rsp_data1), 32'(sl1_data[cyc % 8]));
        if (sl3_mask[cyc % 8] != '0) chk("rsp_data_l3", 32'(rsp_data3), 32'(sl3_data[cyc % 8]));
        chk("access_cnt_l1", acc1, 32'(m_acc));
        chk("access_cnt_l3", acc3, 32'(m_acc));
        chk("coalesce_cnt_l1", coal1, 32'(m_coal));
        chk("coalesce_cnt_l3", coal3, 32'(m_coal));

        if (!rst) begin
            sl1_mask[cyc % 8] = '0;
            sl3_mask[cyc % 8] = '0;
            if (win >= 0) begin
                m_ptr = (win + 1) % NU;
                m_en = 1'b1;
                m_addr = ua[win];
                sl1_mask[(cyc + 2) % 8] = m_mask;
                sl1_data[(cyc + 2) % 8] = mem_fn(ua[win]);
                sl3_mask[(cyc + 4) % 8] = m_mask;
                sl3_data[(cyc + 4) % 8] = mem_fn(ua[win]);
                m_acc++;
                m_coal += $countones(m_mask) - 1;
                winners.push_back(win);
            end else begin
                m_en = 1'b0;
            end
        end
        cyc++;
    end

    task automatic default_addrs();
        for (int j = 0; j < NU; j++) ua[j] = AW'(j * 17'h00111 + 17'h00200);
    endtask

    initial begin
        default_addrs();
        repeat (3) @(negedge clk);
        #3;
        chk("rst_mem_en", 32'(mem_en1), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'h0);
        chk("rst_access_cnt", acc1, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // single unit 3 at 0x00100
        @(negedge clk); ua[3] = 17'h00100; req_valid = 16'h0008;
        #3 chk("single_ready", 32'(ready1), 32'h0008);
        @(negedge clk); req_valid = '0;
        #3 chk("single_mem_en", 32'(mem_en1), 32'h1);
        chk("single_mem_addr", 32'(mem_addr1), 32'h00100);
        @(negedge clk);
        #3 chk("single_rsp_valid", 32'(rsp_valid1), 32'h0008);
        chk("single_rsp_data", 32'(rsp_data1), 32'hA5);
        @(negedge clk);
        @(negedge clk);
        #3 chk("single_rsp_valid_l3", 32'(rsp_valid3), 32'h0008);
        chk("single_rsp_data_l3", 32'(rsp_data3), 32'hA5);

        // pointer wrap then idle
        @(negedge clk); req_valid = 16'h8000;
        #3 chk("wrap_ready15", 32'(ready1), 32'h8000);
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk);
        @(negedge clk); req_valid = 16'h8001;
        #3 chk("wrap_first0", 32'(ready1), 32'h0001);
        @(negedge clk); req_valid = 16'h8000;
        #3 chk("wrap_then15", 32'(ready1), 32'h8000);
        @(negedge clk); req_valid = '0;

        // coalescing with ptr back at 0
        @(negedge clk);
        ua[2] = 17'h1F000; ua[5] = 17'h1F000; ua[9] = 17'h1F000; ua[4] = 17'h00010;
        req_valid = 16'h0234;
        #3 chk("coal_grant1", 32'(ready1), 32'h0224);
        @(negedge clk); req_valid = 16'h0010;
        #3 chk("coal_grant2", 32'(ready1), 32'h0010);
        @(negedge clk); req_valid = '0;
        #3 chk("coal_rsp1", 32'(rsp_valid1), 32'h0224);
        @(negedge clk);
        #3 chk("coal_rsp2", 32'(rsp_valid1), 32'h0010);
        chk("coal_cnt", coal1, 32'h2);
        repeat (3) @(negedge clk);

        // reset with accesses in flight, then round robin from reset
        @(negedge clk); default_addrs(); req_valid = 16'h0F0F;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        #3 chk("midrst_mem_en", 32'(mem_en3), 32'h0);
        chk("midrst_rsp1", 32'(rsp_valid1), 32'h0);
        chk("midrst_rsp3", 32'(rsp_valid3), 32'h0);
        chk("midrst_acc", acc3, 32'h0);
        chk("midrst_coal", coal1, 32'h0);
        @(negedge clk); req_valid = '1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            chk("rr_ready", 32'(ready1), 32'(NU'(1) << (k % 16)));
            if (k >= 2) chk("rr_rsp_l1", 32'(rsp_valid1), 32'(NU'(1) << (k - 2)));
            if (k >= 4) chk("rr_rsp_l3", 32'(rsp_valid3), 32'(NU'(1) << (k - 4)));
            if (k == 16) chk("rr_access_cnt", acc1, 32'd16);
        end
        @(negedge clk); req_valid = '0;
        repeat (6) @(negedge clk);
        chk("rr_grant_count", 32'(winners.size()), 32'd17);
        for (int k = 0; k < 17 && k < winners.size(); k++)
            chk("rr_order", 32'(winners[k]), 32'(k % 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
